// File: rtl/sdram_frame_arbiter.sv
// Burst arbiter sharing one SDRAM between the capture writer and the VGA reader.
// Define FRAME_PINGPONG_EN to alternate write/read frames between FRAME_BASE0 and FRAME_BASE1.
module sdram_frame_arbiter #(
   parameter int                ADDR_W      = 22,
   parameter int                LVL_W       = 10,
   parameter int                BURST_LEN   = 8,
   parameter int                FRAME_WORDS = 414720,
   parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(22'h000000),
   parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(22'h080000),
   parameter int                RD_URGENT   = 448
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [LVL_W-1:0]  iWR_LEVEL,
   input  logic [LVL_W-1:0]  iRD_FREE,
   input  logic              iWR_SOF,
   input  logic              iRD_SOF,
   output logic              oMEM_REQ,
   output logic              oMEM_WE,
   output logic [ADDR_W-1:0] oMEM_ADDR,
   input  logic              iMEM_ACK,
   input  logic              iMEM_DONE,
   output logic              oWR_ACTIVE,
   output logic              oRD_ACTIVE,
   output logic              oWR_WRAP,
   output logic              oRD_FRAME
);

   localparam logic [ADDR_W-1:0] L_STEP      = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] L_LAST_OFF  = ADDR_W'(FRAME_WORDS - BURST_LEN);
   localparam logic [LVL_W-1:0]  L_BURST_LVL = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]  L_URGENT    = LVL_W'(RD_URGENT);
`ifdef FRAME_PINGPONG_EN
   localparam logic              L_RD_FRAME_RST = 1'b1;
`else
   localparam logic              L_RD_FRAME_RST = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_off;
   logic [ADDR_W-1:0] r_rd_off;
   logic              r_wr_frame;
   logic              r_rd_frame;
   logic              r_rr_rd;
   logic              r_wr_sof_pend;
   logic              r_rd_sof_pend;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wr_active;
   logic              r_rd_active;
   logic              r_wr_wrap;

   logic              w_wr_elig;
   logic              w_rd_elig;
   logic              w_rd_urgent;
   logic              w_pick_rd;
   logic              w_any_elig;
   logic [ADDR_W-1:0] w_wr_off_eff;
   logic [ADDR_W-1:0] w_rd_off_eff;
   logic              w_wr_frame_eff;
   logic              w_rd_frame_eff;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;

   // Pending frame starts take effect in the same IDLE cycle that arbitrates.
   assign w_wr_off_eff   = r_wr_sof_pend ? '0 : r_wr_off;
   assign w_rd_off_eff   = r_rd_sof_pend ? '0 : r_rd_off;
`ifdef FRAME_PINGPONG_EN
   assign w_wr_frame_eff = r_wr_frame ^ r_wr_sof_pend;
   assign w_rd_frame_eff = r_rd_sof_pend ? ~w_wr_frame_eff : r_rd_frame;
`else
   assign w_wr_frame_eff = r_wr_frame;
   assign w_rd_frame_eff = r_rd_frame;
`endif

   assign w_wr_addr   = (w_wr_frame_eff ? FRAME_BASE1 : FRAME_BASE0) + w_wr_off_eff;
   assign w_rd_addr   = (w_rd_frame_eff ? FRAME_BASE1 : FRAME_BASE0) + w_rd_off_eff;

   assign w_wr_elig   = (iWR_LEVEL >= L_BURST_LVL);
   assign w_rd_elig   = (iRD_FREE >= L_BURST_LVL);
   assign w_rd_urgent = w_rd_elig && (iRD_FREE >= L_URGENT);
   assign w_any_elig  = w_wr_elig || w_rd_elig;
   assign w_pick_rd   = w_rd_urgent || (w_rd_elig && (!w_wr_elig || r_rr_rd));

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state       <= S_IDLE;
         r_wr_off      <= '0;
         r_rd_off      <= '0;
         r_wr_frame    <= 1'b0;
         r_rd_frame    <= L_RD_FRAME_RST;
         r_rr_rd       <= 1'b0;
         r_wr_sof_pend <= 1'b0;
         r_rd_sof_pend <= 1'b0;
         r_req         <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wr_active   <= 1'b0;
         r_rd_active   <= 1'b0;
         r_wr_wrap     <= 1'b0;
      end else begin
         r_wr_wrap <= 1'b0;
         if (r_state == S_IDLE) begin
            r_wr_sof_pend <= iWR_SOF;
            r_rd_sof_pend <= iRD_SOF;
         end else begin
            r_wr_sof_pend <= r_wr_sof_pend | iWR_SOF;
            r_rd_sof_pend <= r_rd_sof_pend | iRD_SOF;
         end

         case (r_state)
            S_IDLE: begin
               r_wr_off   <= w_wr_off_eff;
               r_rd_off   <= w_rd_off_eff;
               r_wr_frame <= w_wr_frame_eff;
               r_rd_frame <= w_rd_frame_eff;
               if (w_any_elig) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_we    <= !w_pick_rd;
                  r_addr  <= w_pick_rd ? w_rd_addr : w_wr_addr;
               end
            end
            S_REQ: begin
               if (iMEM_ACK) begin
                  r_state     <= S_BUSY;
                  r_req       <= 1'b0;
                  r_wr_active <= r_we;
                  r_rd_active <= !r_we;
               end
            end
            S_BUSY: begin
               if (iMEM_DONE) begin
                  r_state     <= S_IDLE;
                  r_wr_active <= 1'b0;
                  r_rd_active <= 1'b0;
                  // Served port loses priority for the next tie.
                  if (r_we) begin
                     r_rr_rd <= 1'b1;
                     if (r_wr_off >= L_LAST_OFF) begin
                        r_wr_off  <= '0;
                        r_wr_wrap <= 1'b1;
                     end else begin
                        r_wr_off  <= r_wr_off + L_STEP;
                     end
                  end else begin
                     r_rr_rd <= 1'b0;
                     if (r_rd_off >= L_LAST_OFF) begin
                        r_rd_off <= '0;
                     end else begin
                        r_rd_off <= r_rd_off + L_STEP;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign oMEM_REQ   = r_req;
   assign oMEM_WE    = r_we;
   assign oMEM_ADDR  = r_addr;
   assign oWR_ACTIVE = r_wr_active;
   assign oRD_ACTIVE = r_rd_active;
   assign oWR_WRAP   = r_wr_wrap;
   assign oRD_FRAME  = r_rd_frame;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: directed scenarios then random bursts against a burst-level model.
// Works with or without FRAME_PINGPONG_EN defined.
module tb_sdram_frame_arbiter;

   localparam int ADDR_W      = 22;
   localparam int LVL_W       = 10;
   localparam int BURST_LEN   = 8;
   localparam int FRAME_WORDS = 96;
   localparam int RD_URGENT   = 448;
   localparam int BASE0       = 32'h000000;
   localparam int BASE1       = 32'h080000;
`ifdef FRAME_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [LVL_W-1:0]  wr_level = '0;
   logic [LVL_W-1:0]  rd_free = '0;
   logic              wr_sof = 1'b0;
   logic              rd_sof = 1'b0;
   logic              mem_ack = 1'b0;
   logic              mem_done = 1'b0;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              wr_active;
   logic              rd_active;
   logic              wr_wrap;
   logic              rd_frame;

   sdram_frame_arbiter #(
      .ADDR_W(ADDR_W), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS),
      .FRAME_BASE0(22'h000000), .FRAME_BASE1(22'h080000), .RD_URGENT(RD_URGENT)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n), .iWR_LEVEL(wr_level), .iRD_FREE(rd_free),
      .iWR_SOF(wr_sof), .iRD_SOF(rd_sof), .oMEM_REQ(mem_req), .oMEM_WE(mem_we),
      .oMEM_ADDR(mem_addr), .iMEM_ACK(mem_ack), .iMEM_DONE(mem_done),
      .oWR_ACTIVE(wr_active), .oRD_ACTIVE(rd_active), .oWR_WRAP(wr_wrap), .oRD_FRAME(rd_frame)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int n_bursts = 0;
   int lat;

   // Burst-level model of the frame buffer pointers
   int m_wr_off, m_rd_off, m_addr;
   bit m_wr_frame, m_rd_frame, m_next_rd, m_wr_pend, m_rd_pend, m_we;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_base(input bit f);
      return f ? BASE1 : BASE0;
   endfunction

   function automatic void model_reset();
      m_wr_off = 0; m_rd_off = 0; m_wr_frame = 1'b0; m_rd_frame = PP;
      m_next_rd = 1'b0; m_wr_pend = 1'b0; m_rd_pend = 1'b0;
   endfunction

   function automatic void model_apply_sof();
      if (m_wr_pend) begin
         m_wr_off = 0;
         if (PP) m_wr_frame = !m_wr_frame;
      end
      if (m_rd_pend) begin
         m_rd_off = 0;
         if (PP) m_rd_frame = !m_wr_frame;
      end
      m_wr_pend = 1'b0;
      m_rd_pend = 1'b0;
   endfunction

   function automatic void model_decide(input int wl, input int rf);
      model_apply_sof();
      if (rf >= RD_URGENT) m_we = 1'b0;
      else if (wl >= BURST_LEN && rf >= BURST_LEN) m_we = !m_next_rd;
      else m_we = (wl >= BURST_LEN);
      m_addr = m_we ? frame_base(m_wr_frame) + m_wr_off : frame_base(m_rd_frame) + m_rd_off;
   endfunction

   function automatic int rand_lvl();
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 7));
         1: return int'($urandom_range(8, 447));
         2: return int'($urandom_range(448, 1023));
         default: return int'($urandom_range(8, 64));
      endcase
   endfunction

   // One full burst: request check, ACK, busy phase (optional SOFs), DONE with next levels.
   task automatic run_burst(input int ack_dly, input int busy_dly, input int nwl, input int nrf,
                            input bit sw, input bit sr, input bit s_done);
      bit exp_wrap;
      model_decide(int'(wr_level), int'(rd_free));
      lat = 0;
      while (!mem_req && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("req_seen", {31'd0, mem_req}, 1);
      if (!mem_req) return;
      n_bursts++;
      $display("burst %0d: %s addr=0x%06h wr_lvl=%0d rd_free=%0d rd_frame=%0d",
               n_bursts, mem_we ? "W" : "R", mem_addr, wr_level, rd_free, rd_frame);
      check_val("we", {31'd0, mem_we}, {31'd0, m_we});
      check_val("addr", {10'd0, mem_addr}, m_addr);
      check_val("rd_frame", {31'd0, rd_frame}, {31'd0, m_rd_frame});
      repeat (ack_dly) @(negedge clk);
      if (ack_dly > 0) check_val("req_hold", {31'd0, mem_req}, 1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check_val("req_drop", {31'd0, mem_req}, 0);
      check_val("wr_active", {31'd0, wr_active}, {31'd0, m_we});
      check_val("rd_active", {31'd0, rd_active}, {31'd0, !m_we});
      for (int i = 0; i < busy_dly; i++) begin
         if (i == 0 && !s_done) begin
            wr_sof = sw;
            rd_sof = sr;
         end
         @(negedge clk);
         wr_sof = 1'b0;
         rd_sof = 1'b0;
      end
      if (!s_done) begin
         m_wr_pend |= sw;
         m_rd_pend |= sr;
      end
      mem_done = 1'b1;
      wr_level = LVL_W'(nwl);
      rd_free  = LVL_W'(nrf);
      if (s_done) begin
         wr_sof = sw;
         rd_sof = sr;
         m_wr_pend |= sw;
         m_rd_pend |= sr;
      end
      @(negedge clk);
      mem_done = 1'b0;
      wr_sof = 1'b0;
      rd_sof = 1'b0;
      exp_wrap = 1'b0;
      if (m_we) begin
         m_wr_off += BURST_LEN;
         if (m_wr_off == FRAME_WORDS) begin
            m_wr_off = 0;
            exp_wrap = 1'b1;
         end
         m_next_rd = 1'b1;
      end else begin
         m_rd_off += BURST_LEN;
         if (m_rd_off == FRAME_WORDS) m_rd_off = 0;
         m_next_rd = 1'b0;
      end
      check_val("wr_wrap", {31'd0, wr_wrap}, {31'd0, exp_wrap});
      check_val("active_clear", {30'd0, wr_active, rd_active}, 0);
      if (exp_wrap) begin
         @(negedge clk);
         check_val("wrap_single", {31'd0, wr_wrap}, 0);
      end
   endtask

   // Nothing eligible: stray ACK/DONE must be ignored, optional SOF, then make a port eligible.
   task automatic idle_gap(input bit sw, input bit sr, input int nwl, input int nrf);
      model_apply_sof();
      repeat (2) begin
         mem_ack = 1'b1;
         mem_done = 1'b1;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      mem_done = 1'b0;
      if (sw || sr) begin
         wr_sof = sw;
         rd_sof = sr;
         m_wr_pend = sw;
         m_rd_pend = sr;
         @(negedge clk);
         wr_sof = 1'b0;
         rd_sof = 1'b0;
      end
      @(negedge clk);
      check_val("idle_no_req", {31'd0, mem_req}, 0);
      wr_level = LVL_W'(nwl);
      rd_free  = LVL_W'(nrf);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_req_low", {31'd0, mem_req}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_req", {31'd0, mem_req}, 0);
      check_val("rst_we", {31'd0, mem_we}, 0);
      check_val("rst_addr", {10'd0, mem_addr}, 0);
      check_val("rst_active", {30'd0, wr_active, rd_active}, 0);
      check_val("rst_wrap", {31'd0, wr_wrap}, 0);
      check_val("rst_rd_frame", {31'd0, rd_frame}, {31'd0, PP});

      // Write only: ADDR 0 one cycle after the decision, then 8
      wr_level = 10'd8;
      rd_free  = 10'd0;
      run_burst(0, 2, 8, 0, 1'b0, 1'b0, 1'b0);
      check_val("req_latency", lat, 1);
      run_burst(1, 1, 64, 64, 1'b0, 1'b0, 1'b0);

      // Both eligible: alternate
      for (int i = 0; i < 3; i++) run_burst(0, 1, 64, 64, 1'b0, 1'b0, 1'b0);
      run_burst(2, 3, 64, 500, 1'b0, 1'b0, 1'b0);

      // Urgent reads, then round-robin again
      for (int i = 0; i < 2; i++) run_burst(0, 1, 64, 500, 1'b0, 1'b0, 1'b0);
      run_burst(0, 1, 64, 100, 1'b0, 1'b0, 1'b0);
      run_burst(0, 1, 64, 100, 1'b0, 1'b0, 1'b0);
      run_burst(0, 1, 8, 0, 1'b0, 1'b0, 1'b0);

      // Write wrap at end of frame
      for (int i = 0; i < 20 && m_wr_off != FRAME_WORDS - BURST_LEN; i++)
         run_burst(0, 1, 8, 0, 1'b0, 1'b0, 1'b0);
      run_burst(0, 1, 8, 0, 1'b0, 1'b0, 1'b0);
      run_burst(0, 1, 8, 0, 1'b0, 1'b0, 1'b0);

      // Frame starts: mid-burst write SOF, read SOF, SOF together with DONE, both at once
      run_burst(0, 2, 8, 0, 1'b1, 1'b0, 1'b0);
      run_burst(0, 1, 0, 64, 1'b0, 1'b1, 1'b0);
      run_burst(0, 1, 0, 64, 1'b0, 1'b0, 1'b0);
      run_burst(1, 2, 8, 8, 1'b1, 1'b0, 1'b1);
      run_burst(0, 1, 8, 8, 1'b1, 1'b1, 1'b1);
      run_burst(0, 1, 8, 0, 1'b0, 1'b0, 1'b0);

      // Reset during BUSY
      lat = 0;
      while (!mem_req && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("pre_rst_req", {31'd0, mem_req}, 1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check_val("pre_rst_wr_active", {31'd0, wr_active}, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_req", {31'd0, mem_req}, 0);
      check_val("rst_mid_wr_active", {31'd0, wr_active}, 0);
      check_val("rst_mid_rd_frame", {31'd0, rd_frame}, {31'd0, PP});
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      run_burst(0, 1, 64, 64, 1'b0, 1'b0, 1'b0);
      check_val("post_rst_latency", lat, 1);

      // Random traffic
      for (int n = 0; n < 150; n++) begin
         int nwl, nrf;
         bit sw, sr, sd;
         nwl = rand_lvl();
         nrf = rand_lvl();
         sw  = ($urandom_range(0, 5) == 0);
         sr  = ($urandom_range(0, 5) == 0);
         sd  = $urandom_range(0, 1) == 1;
         run_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), nwl, nrf, sw, sr, sd);
         if (nwl < BURST_LEN && nrf < BURST_LEN)
            idle_gap($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     int'($urandom_range(8, 200)), rand_lvl());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
